ids_dma: RTL and testbench
==========================

Name: ids_dma

Overview:
- Single-channel word-copy DMA engine; the DMA master that sits directly upstream of the IDS bus DMA port.
- Copies LEN 32-bit words from a DMEM source region to a DMEM destination region. It requests the shared DMEM port through the bus arbiter's req/gnt handshake.
- Configured by the core through a small MMIO register file. Raises done/irq on completion.

Parameters:
- LEN_W, 16, width of transfer length register in words (max 2^LEN_W-1 words)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_write  in  1  config register write strobe
- i_cfg_addr  in  4  config byte offset (0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL)
- i_cfg_wdata  in  32  config write data
- o_cfg_rdata  out  32  config read data, combinational on i_cfg_addr
- o_irq  out  1  level interrupt = done & irq_en
- o_req_dma  out  1  bus request to arbiter
- i_gnt_dma  in  1  bus grant from arbiter
- o_dma_addr  out  32  bus address, word aligned
- o_dma_write  out  1  write strobe
- o_dma_read  out  1  read strobe
- o_dma_size  out  4  byte enables, always 4'b1111
- o_dma_din  out  32  write data
- i_dma_dout  in  32  read data, valid the cycle after an accepted read

Behaviour:
- Reset (async, i_rst_n=0): SRC=DST=0, LEN=0, busy=0, done=0, irq_en=0, FSM=IDLE, data buffer=0. All bus outputs 0 except o_dma_size=4'b1111. o_irq=0.
- Registers:
  - SRC[31:2] at 0x0, DST[31:2] at 0x4; bits[1:0] read 0.
  - LEN[LEN_W-1:0] at 0x8.
  - CTRL at 0xC: bit0 start (write-1 pulse, reads 0), bit1 busy (RO), bit2 done (W1C), bit3 irq_en (RW).
- Register write rules:
  - Writes to SRC/DST/LEN while busy are ignored.
  - A start write while busy is ignored.
  - A CTRL write takes irq_en and the done-clear regardless of busy.
  - Reads of unmapped offsets return 0.
- Start (busy=0, start=1):
  - Copy SRC/DST/LEN into working counters rd_addr, wr_addr, remain.
  - Set busy=1, clear done.
  - LEN=0: set done=1 next cycle, busy stays 0, no bus traffic.
- FSM, one state per cycle:
  - IDLE -> RD on start with LEN!=0.
  - RD: o_req_dma=1, o_dma_read=1, o_dma_addr=rd_addr. The read is accepted only in a cycle with i_gnt_dma=1; then rd_addr+=4 and go to CAP. Otherwise stay in RD.
  - CAP: o_req_dma=1, no strobes. Capture i_dma_dout into the buffer unconditionally (the SRAM already issued the read), regardless of gnt. Go to WR.
  - WR: o_req_dma=1, o_dma_write=1, o_dma_addr=wr_addr, o_dma_din=buffer. Accepted when i_gnt_dma=1; then wr_addr+=4 and remain-=1.
    - If remain was 1: go to IDLE, busy=0, done=1.
    - Otherwise go to RD.
    - Not granted: stay in WR, holding addr/data stable.
- Strobes are asserted only in RD/WR. Address/data are stable while waiting for grant.
- o_req_dma is deasserted in IDLE.
- Throughput: 3 cycles per word with continuous grant. Latency start->done = 3*LEN+1 cycles.
- Addresses increment modulo 2^32 (wrap 0xFFFF_FFFC -> 0x0000_0000); no error.
- Overlapping regions: a strict forward copy, word by word; no overlap handling.
- Done is held until cleared by W1C or by the next start. Done-clear and completion in the same cycle: completion wins.
- Reset mid-transfer aborts immediately to the reset state; partially written destination is left as is.

Test Plan:
- SRC=0x1000, DST=0x1100, LEN=4, gnt tied 1, source words 0xA0..0xA3:
  - Required: reads at 0x1000..0x100C, writes at 0x1100..0x110C with data 0xA0..0xA3.
  - done=1 exactly 13 cycles after the start write; irq rises only if irq_en=1.
- Same copy with gnt dropped for 5 cycles during WR of word 2 and 3 cycles during RD of word 3:
  - Required: strobe/addr/din held stable while ungranted.
  - Each address accessed exactly once; final data correct; total 21 cycles.
- LEN=0 start: required no o_req_dma assertion, done=1 one cycle later, busy never 1.
- Config writes while busy (SRC=0x2000, second start):
  - Required: ignored; transfer completes with original parameters; SRC reads old value.
- SRC=0xFFFF_FFF8, LEN=3: required read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Async reset asserted during CAP of word 2: required all outputs at reset values immediately, busy=0, done=0. A new start afterwards runs normally.

Source files
------------

// File: rtl/ids_dma.sv
// rtl/ids_dma.sv - single-channel word-copy DMA engine with MMIO config registers
// Copies LEN words from SRC to DST over the arbitrated DMEM port, one word per RD/CAP/WR pass.
module ids_dma #(
   parameter int LEN_W = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cfg_write,
   input  logic [3:0]  i_cfg_addr,
   input  logic [31:0] i_cfg_wdata,
   output logic [31:0] o_cfg_rdata,
   output logic        o_irq,
   output logic        o_req_dma,
   input  logic        i_gnt_dma,
   output logic [31:0] o_dma_addr,
   output logic        o_dma_write,
   output logic        o_dma_read,
   output logic [3:0]  o_dma_size,
   output logic [31:0] o_dma_din,
   input  logic [31:0] i_dma_dout
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:2]       r_src;
   logic [31:2]       r_dst;
   logic [31:2]       r_rd_addr;
   logic [31:2]       r_wr_addr;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_remain;
   logic              r_busy;
   logic              r_done;
   logic              r_irq_en;
   logic [31:0]       r_buf;

   logic              w_cfg_en;
   logic              w_ctrl_wr;
   logic              w_start;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_last;

   assign w_cfg_en  = i_cfg_write && !r_busy;
   assign w_ctrl_wr = i_cfg_write && (i_cfg_addr == 4'hC);
   assign w_start   = w_ctrl_wr && i_cfg_wdata[0] && !r_busy;
   assign w_rd_acc  = (r_state == S_RD) && i_gnt_dma;
   assign w_wr_acc  = (r_state == S_WR) && i_gnt_dma;
   assign w_last    = w_wr_acc && (r_remain == LEN_W'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_req_dma   = 1'b0;
      o_dma_read  = 1'b0;
      o_dma_write = 1'b0;
      o_dma_addr  = 32'h0;
      o_dma_din   = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (w_start && (r_len != '0)) w_state_nxt = S_RD;
         end
         S_RD: begin
            o_req_dma  = 1'b1;
            o_dma_read = 1'b1;
            o_dma_addr = {r_rd_addr, 2'b00};
            if (i_gnt_dma) w_state_nxt = S_CAP;
         end
         S_CAP: begin
            o_req_dma   = 1'b1;
            w_state_nxt = S_WR;
         end
         S_WR: begin
            o_req_dma   = 1'b1;
            o_dma_write = 1'b1;
            o_dma_addr  = {r_wr_addr, 2'b00};
            o_dma_din   = r_buf;
            if (i_gnt_dma) w_state_nxt = (r_remain == LEN_W'(1)) ? S_IDLE : S_RD;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Later assignments take priority: start overrides the done-clear, completion overrides both.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_remain  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_buf     <= 32'h0;
      end else begin
         if (w_cfg_en && (i_cfg_addr == 4'h0)) r_src <= i_cfg_wdata[31:2];
         if (w_cfg_en && (i_cfg_addr == 4'h4)) r_dst <= i_cfg_wdata[31:2];
         if (w_cfg_en && (i_cfg_addr == 4'h8)) r_len <= i_cfg_wdata[LEN_W-1:0];
         if (w_ctrl_wr) begin
            r_irq_en <= i_cfg_wdata[3];
            if (i_cfg_wdata[2]) r_done <= 1'b0;
         end
         if (w_start) begin
            r_rd_addr <= r_src;
            r_wr_addr <= r_dst;
            r_remain  <= r_len;
            if (r_len == '0) begin
               r_done <= 1'b1;
            end else begin
               r_busy <= 1'b1;
               r_done <= 1'b0;
            end
         end
         if (w_rd_acc) r_rd_addr <= r_rd_addr + 30'd1;
         // The SRAM answers the read accepted last cycle, so capture without looking at the grant.
         if (r_state == S_CAP) r_buf <= i_dma_dout;
         if (w_wr_acc) begin
            r_wr_addr <= r_wr_addr + 30'd1;
            r_remain  <= r_remain - LEN_W'(1);
         end
         if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   always_comb begin
      o_cfg_rdata = 32'h0;
      case (i_cfg_addr)
         4'h0:    o_cfg_rdata = {r_src, 2'b00};
         4'h4:    o_cfg_rdata = {r_dst, 2'b00};
         4'h8:    o_cfg_rdata = 32'(r_len);
         4'hC:    o_cfg_rdata = {28'h0, r_irq_en, r_done, r_busy, 1'b0};
         default: o_cfg_rdata = 32'h0;
      endcase
   end

   assign o_dma_size = 4'b1111;
   assign o_irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_ids_dma.sv
// tb/tb_ids_dma.sv - scoreboard bench for ids_dma
// Reference model expands each programmed copy into the expected bus transaction list.
module tb_ids_dma;
   localparam int LEN_W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_write = 1'b0;
   logic [3:0]  cfg_addr = 4'h0;
   logic [31:0] cfg_wdata = 32'h0;
   logic [31:0] cfg_rdata;
   logic        irq;
   logic        req;
   logic        gnt = 1'b1;
   logic [31:0] dma_addr;
   logic        dma_write;
   logic        dma_read;
   logic [3:0]  dma_size;
   logic [31:0] dma_din;
   logic [31:0] dma_dout = 32'h0;

   ids_dma #(.LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_write(cfg_write), .i_cfg_addr(cfg_addr),
      .i_cfg_wdata(cfg_wdata), .o_cfg_rdata(cfg_rdata), .o_irq(irq), .o_req_dma(req),
      .i_gnt_dma(gnt), .o_dma_addr(dma_addr), .o_dma_write(dma_write), .o_dma_read(dma_read),
      .o_dma_size(dma_size), .o_dma_din(dma_din), .i_dma_dout(dma_dout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;
   txn_t exp_q[$];

   logic [31:0] sram [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   bit          rand_gnt = 1'b0;
   int          stall_w_left = 0;
   logic [31:0] stall_w_addr = 32'h0;
   int          stall_r_left = 0;
   logic [31:0] stall_r_addr = 32'h0;
   bit          req_seen = 1'b0;
   int          rd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fill(input logic [31:0] a);
      return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
   endfunction
   function automatic logic [31:0] sram_rd(input logic [31:0] a);
      return sram.exists(a) ? sram[a] : fill(a);
   endfunction
   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // Grant driver: optional targeted stalls, otherwise constant or random grant.
   always @(posedge clk) begin
      #2;
      if (stall_w_left > 0 && dma_write && dma_addr == stall_w_addr) begin
         gnt = 1'b0;
         stall_w_left--;
      end else if (stall_r_left > 0 && dma_read && dma_addr == stall_r_addr) begin
         gnt = 1'b0;
         stall_r_left--;
      end else begin
         gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   always @(posedge clk) begin
      #1;
      dma_dout = pend ? sram_rd(pend_addr) : $urandom;
      pend = 1'b0;
   end

   bit          prev_stall = 1'b0;
   logic        prev_rd = 1'b0;
   logic        prev_wr = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] prev_din = 32'h0;
   always @(negedge clk) begin
      txn_t t;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("size", {28'h0, dma_size}, 32'hF);
         if (req) req_seen = 1'b1;
         if (dma_read || dma_write) chk("req_with_strobe", {31'h0, req}, 32'h1);
         if (prev_stall) begin
            chk("hold_read", {31'h0, dma_read}, {31'h0, prev_rd});
            chk("hold_write", {31'h0, dma_write}, {31'h0, prev_wr});
            chk("hold_addr", dma_addr, prev_addr);
            if (prev_wr) chk("hold_din", dma_din, prev_din);
         end
         prev_stall = (dma_read || dma_write) && !gnt;
         prev_rd = dma_read;
         prev_wr = dma_write;
         prev_addr = dma_addr;
         prev_din = dma_din;
         if (gnt && (dma_read || dma_write)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL bus_unexpected: got wr=%0d addr %h, expected no transaction", dma_write, dma_addr);
            end else begin
               t = exp_q.pop_front();
               chk("bus_kind", {31'h0, dma_write}, {31'h0, t.wr});
               chk("bus_addr", dma_addr, t.addr);
               if (dma_write) chk("bus_data", dma_din, t.data);
            end
            if (dma_read) begin
               pend = 1'b1;
               pend_addr = dma_addr;
               rd_cnt++;
            end
            if (dma_write) sram[dma_addr] = dma_din;
         end
      end
   end

   task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_write = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_write = 1'b0;
   endtask

   task automatic cfg_rd(input logic [3:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic setup(input logic [31:0] src, input logic [31:0] dst, input int len);
      logic [31:0] v;
      logic [31:0] a;
      cfg_wr(4'h0, src);
      cfg_wr(4'h4, dst);
      cfg_wr(4'h8, len);
      cfg_rd(4'h0, v); chk("src_readback", v, src & 32'hFFFF_FFFC);
      cfg_rd(4'h4, v); chk("dst_readback", v, dst & 32'hFFFF_FFFC);
      cfg_rd(4'h8, v); chk("len_readback", v, len);
      for (int i = 0; i < len; i++) begin
         a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
         exp_q.push_back('{1'b0, a, 32'h0});
         v = ref_rd(a);
         a = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
         exp_q.push_back('{1'b1, a, v});
         ref_mem[a] = v;
      end
   endtask

   task automatic start(input bit ien);
      cfg_wr(4'hC, {28'h0, ien, 3'b001});
   endtask

   task automatic wait_done(output int lat, output bit saw_busy);
      logic [31:0] c;
      lat = -1;
      saw_busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         cfg_rd(4'hC, c);
         if (c[1]) saw_busy = 1'b1;
         if (c[2]) begin
            lat = n + 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         n_checks++;
         n_err++;
         $display("FAIL done_timeout: got no done within 3000 cycles, expected done");
      end
   endtask

   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit ien, input int exp_lat);
      int lat;
      bit saw_busy;
      logic [31:0] c;
      setup(src, dst, len);
      start(ien);
      wait_done(lat, saw_busy);
      if (exp_lat >= 0) chk("latency", lat, exp_lat);
      chk("busy_seen", {31'h0, saw_busy}, {31'h0, len > 0});
      cfg_rd(4'hC, c);
      chk("busy_after_done", {31'h0, c[1]}, 32'h0);
      chk("irq", {31'h0, irq}, {31'h0, ien});
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      logic [31:0] v;
      int lat;
      bit saw_busy;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'h0, req}, 32'h0);
      chk("rst_read", {31'h0, dma_read}, 32'h0);
      chk("rst_write", {31'h0, dma_write}, 32'h0);
      chk("rst_addr", dma_addr, 32'h0);
      chk("rst_din", dma_din, 32'h0);
      chk("rst_size", {28'h0, dma_size}, 32'hF);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      cfg_rd(4'h0, v); chk("rst_src", v, 32'h0);
      cfg_rd(4'h8, v); chk("rst_len", v, 32'h0);
      cfg_rd(4'hC, v); chk("rst_ctrl", v, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         sram[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
         ref_mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      end
      run_copy(32'h1000, 32'h1100, 4, 1'b0, 13);
      run_copy(32'h1000, 32'h1100, 4, 1'b1, 13);
      cfg_wr(4'hC, 32'hC);
      cfg_rd(4'hC, v);
      chk("done_w1c", v, 32'h8);
      chk("irq_after_w1c", {31'h0, irq}, 32'h0);
      cfg_wr(4'hC, 32'h0);
      cfg_rd(4'h1, v); chk("unmapped_read", v, 32'h0);

      stall_w_addr = 32'h1104; stall_w_left = 5;
      stall_r_addr = 32'h1008; stall_r_left = 3;
      run_copy(32'h1000, 32'h1100, 4, 1'b0, 21);
      chk("stall_w_used", stall_w_left, 0);
      chk("stall_r_used", stall_r_left, 0);
      for (int i = 0; i < 4; i++) chk("copy_data", sram_rd(32'h1100 + 32'(4 * i)), 32'hA0 + 32'(i));

      req_seen = 1'b0;
      run_copy(32'h1000, 32'h1200, 0, 1'b0, 1);
      @(posedge clk); #1;
      chk("len0_no_req", {31'h0, req_seen}, 32'h0);

      setup(32'h3000, 32'h3100, 5);
      start(1'b0);
      @(posedge clk); #1;
      cfg_rd(4'hC, v); chk("busy_mid", {31'h0, v[1]}, 32'h1);
      cfg_wr(4'h0, 32'h2000);
      cfg_wr(4'h4, 32'h2100);
      cfg_wr(4'h8, 32'h9);
      cfg_wr(4'hC, 32'h1);
      wait_done(lat, saw_busy);
      chk("busy_cfg_drained", exp_q.size(), 0);
      cfg_rd(4'h0, v); chk("busy_src_kept", v, 32'h3000);
      cfg_rd(4'h4, v); chk("busy_dst_kept", v, 32'h3100);
      cfg_rd(4'h8, v); chk("busy_len_kept", v, 32'h5);

      run_copy(32'hFFFF_FFF8, 32'h600, 3, 1'b0, 10);

      setup(32'h4000, 32'h4100, 4);
      start(1'b1);
      begin
         int n = 0;
         int base = rd_cnt;
         while (rd_cnt < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
         end
         chk("reach_cap2", {31'h0, rd_cnt >= base + 2}, 32'h1);
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'h0, req}, 32'h0);
      chk("arst_strobes", {30'h0, dma_read, dma_write}, 32'h0);
      chk("arst_addr", dma_addr, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      cfg_rd(4'hC, v); chk("arst_ctrl", v, 32'h0);
      exp_q.delete();
      ref_mem = sram;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_copy(32'h4000, 32'h4200, 3, 1'b1, 10);

      rand_gnt = 1'b1;
      for (int k = 0; k < 6; k++) begin
         run_copy(32'h8000 + 32'($urandom_range(0, 31) * 4), 32'h8000 + 32'($urandom_range(0, 31) * 4),
                  int'($urandom_range(1, 12)), 1'(k % 2), -1);
      end
      rand_gnt = 1'b0;
      repeat (3) @(posedge clk);
      chk("final_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
